// File: rtl/hazard_pkg.sv
// Shared definitions for the forwarding / hazard unit: multdiv FSM encoding and
// the register that an excepting stage writes by default.
package hazard_pkg;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_WB   = 2'd2
    } md_state_t;

    localparam int EXC_REG_DEFAULT = 30;

endpackage

// File: rtl/fwd_mux.sv
// One ALU operand select: youngest matching stage wins, then multdiv writeback,
// then the register-file value latched in DX.
module fwd_mux #(
    parameter int DATA_W  = 32,
    parameter int REG_AW  = 5,
    parameter int NUM_FWD = 2
) (
    input  logic [REG_AW-1:0]         rs,
    input  logic                      vld,
    input  logic [NUM_FWD-1:0]        we,
    input  logic [NUM_FWD*REG_AW-1:0] rd,
    input  logic [NUM_FWD*DATA_W-1:0] data,
    input  logic                      md_vld,
    input  logic [REG_AW-1:0]         md_rd,
    input  logic [DATA_W-1:0]         md_data,
    input  logic [DATA_W-1:0]         rf_data,
    output logic [DATA_W-1:0]         y
);

    logic can_fwd;

    assign can_fwd = vld && (rs != '0);

    // Walk oldest to youngest so the lowest matching index overrides.
    always_comb begin
        y = rf_data;
        if (can_fwd && md_vld && (md_rd == rs))
            y = md_data;
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
            if (can_fwd && we[i] && (rd[i*REG_AW +: REG_AW] == rs))
                y = data[i*DATA_W +: DATA_W];
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Operand/store-data forwarding, load-use and multdiv interlocks, and a
// saturating stall counter for a simple in-order pipeline.
module fwd_hazard_unit
    import hazard_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int REG_AW  = 5,
    parameter int NUM_FWD = 2,
    parameter int EXC_REG = EXC_REG_DEFAULT,
    parameter int CNT_W   = 16
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [REG_AW-1:0]         dx_rs1,
    input  logic [REG_AW-1:0]         dx_rs2,
    input  logic                      dx_rs1_vld,
    input  logic                      dx_rs2_vld,
    input  logic [DATA_W-1:0]         dx_a,
    input  logic [DATA_W-1:0]         dx_b,
    input  logic [NUM_FWD-1:0]        stg_we,
    input  logic [NUM_FWD*REG_AW-1:0] stg_rd,
    input  logic [NUM_FWD*DATA_W-1:0] stg_data,
    input  logic [NUM_FWD-1:0]        stg_exc,
    input  logic [NUM_FWD-1:0]        stg_load,
    input  logic                      xm_sw,
    input  logic [REG_AW-1:0]         xm_sw_rd,
    input  logic [DATA_W-1:0]         xm_sw_data,
    input  logic                      md_start,
    input  logic [REG_AW-1:0]         md_rd,
    input  logic                      md_rdy,
    input  logic [DATA_W-1:0]         md_result,
    output logic [DATA_W-1:0]         alu_a,
    output logic [DATA_W-1:0]         alu_b,
    output logic [DATA_W-1:0]         dmem_data,
    output logic                      stall,
    output logic                      md_busy,
    output logic                      md_wb_en,
    output logic [REG_AW-1:0]         md_wb_rd,
    output logic [CNT_W-1:0]          stall_cycles
);

    // state   | meaning
    // MD_IDLE | no multdiv in flight; md_start captured unless stalled
    // MD_BUSY | unit computing; consumers of md_rd_q and new starts stall
    // MD_WB   | result on md_result for one cycle, forwarded and written back

    md_state_t                 state, state_nxt;
    logic [REG_AW-1:0]         md_rd_q;
    logic [NUM_FWD-1:0]        we_eff;
    logic [NUM_FWD*REG_AW-1:0] rd_eff;
    logic [REG_AW-1:0]         rd0;
    logic                      load_use;
    logic                      md_hazard;

    // An excepting stage writes EXC_REG regardless of its own destination.
    always_comb begin
        we_eff = '0;
        rd_eff = '0;
        for (int i = 0; i < NUM_FWD; i++) begin
            we_eff[i] = stg_we[i] | stg_exc[i];
            rd_eff[i*REG_AW +: REG_AW] = stg_exc[i] ? REG_AW'(EXC_REG)
                                                    : stg_rd[i*REG_AW +: REG_AW];
        end
    end

    assign rd0 = rd_eff[REG_AW-1:0];

    assign load_use = stg_load[0] && we_eff[0] && (rd0 != '0) &&
                      ((dx_rs1_vld && (dx_rs1 == rd0)) ||
                       (dx_rs2_vld && (dx_rs2 == rd0)));

    assign md_hazard = (state == MD_BUSY) &&
                       (md_start ||
                        ((md_rd_q != '0) &&
                         ((dx_rs1_vld && (dx_rs1 == md_rd_q)) ||
                          (dx_rs2_vld && (dx_rs2 == md_rd_q)))));

    assign stall = load_use || md_hazard;

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= MD_IDLE;
            md_rd_q <= '0;
        end else begin
            state <= state_nxt;
            if ((state == MD_IDLE) && md_start && !stall)
                md_rd_q <= md_rd;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            MD_IDLE: if (md_start && !stall) state_nxt = MD_BUSY;
            MD_BUSY: if (md_rdy)             state_nxt = MD_WB;
            MD_WB:                           state_nxt = MD_IDLE;
            default:                         state_nxt = MD_IDLE;
        endcase
    end

    always_comb begin
        md_busy  = 1'b0;
        md_wb_en = 1'b0;
        md_wb_rd = '0;
        case (state)
            MD_BUSY: md_busy = 1'b1;
            MD_WB: begin
                md_wb_en = 1'b1;
                md_wb_rd = md_rd_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset)
            stall_cycles <= '0;
        else if (stall && (stall_cycles != '1))
            stall_cycles <= stall_cycles + 1'b1;
    end

    fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW), .NUM_FWD(NUM_FWD)) u_mux_a (
        .rs      (dx_rs1),
        .vld     (dx_rs1_vld),
        .we      (we_eff),
        .rd      (rd_eff),
        .data    (stg_data),
        .md_vld  (md_wb_en),
        .md_rd   (md_wb_rd),
        .md_data (md_result),
        .rf_data (dx_a),
        .y       (alu_a)
    );

    fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW), .NUM_FWD(NUM_FWD)) u_mux_b (
        .rs      (dx_rs2),
        .vld     (dx_rs2_vld),
        .we      (we_eff),
        .rd      (rd_eff),
        .data    (stg_data),
        .md_vld  (md_wb_en),
        .md_rd   (md_wb_rd),
        .md_data (md_result),
        .rf_data (dx_b),
        .y       (alu_b)
    );

    // Store data only looks at stages behind XM; XM itself is the store.
    always_comb begin
        dmem_data = xm_sw_data;
        for (int i = NUM_FWD - 1; i >= 1; i--) begin
            if (xm_sw && we_eff[i] && (xm_sw_rd != '0) &&
                (rd_eff[i*REG_AW +: REG_AW] == xm_sw_rd))
                dmem_data = stg_data[i*DATA_W +: DATA_W];
        end
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit; a narrow stall counter makes saturation
// reachable in a few cycles.
module tb_fwd_hazard_unit;

    localparam int DATA_W  = 32;
    localparam int REG_AW  = 5;
    localparam int NUM_FWD = 2;
    localparam int CNT_W   = 4;

    logic                      clock = 1'b0;
    logic                      reset;
    logic [REG_AW-1:0]         dx_rs1, dx_rs2;
    logic                      dx_rs1_vld, dx_rs2_vld;
    logic [DATA_W-1:0]         dx_a, dx_b;
    logic [NUM_FWD-1:0]        stg_we, stg_exc, stg_load;
    logic [NUM_FWD*REG_AW-1:0] stg_rd;
    logic [NUM_FWD*DATA_W-1:0] stg_data;
    logic                      xm_sw;
    logic [REG_AW-1:0]         xm_sw_rd;
    logic [DATA_W-1:0]         xm_sw_data;
    logic                      md_start, md_rdy;
    logic [REG_AW-1:0]         md_rd;
    logic [DATA_W-1:0]         md_result;
    logic [DATA_W-1:0]         alu_a, alu_b, dmem_data;
    logic                      stall, md_busy, md_wb_en;
    logic [REG_AW-1:0]         md_wb_rd;
    logic [CNT_W-1:0]          stall_cycles;

    int checks = 0;
    int errors = 0;

    fwd_hazard_unit #(
        .DATA_W(DATA_W), .REG_AW(REG_AW), .NUM_FWD(NUM_FWD), .EXC_REG(30), .CNT_W(CNT_W)
    ) dut (
        .clock(clock), .reset(reset),
        .dx_rs1(dx_rs1), .dx_rs2(dx_rs2), .dx_rs1_vld(dx_rs1_vld), .dx_rs2_vld(dx_rs2_vld),
        .dx_a(dx_a), .dx_b(dx_b),
        .stg_we(stg_we), .stg_rd(stg_rd), .stg_data(stg_data), .stg_exc(stg_exc),
        .stg_load(stg_load),
        .xm_sw(xm_sw), .xm_sw_rd(xm_sw_rd), .xm_sw_data(xm_sw_data),
        .md_start(md_start), .md_rd(md_rd), .md_rdy(md_rdy), .md_result(md_result),
        .alu_a(alu_a), .alu_b(alu_b), .dmem_data(dmem_data),
        .stall(stall), .md_busy(md_busy), .md_wb_en(md_wb_en), .md_wb_rd(md_wb_rd),
        .stall_cycles(stall_cycles)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_stages();
        stg_we = '0; stg_exc = '0; stg_load = '0; stg_rd = '0; stg_data = '0;
    endtask

    initial begin
        reset = 1'b1;
        dx_rs1 = '0; dx_rs2 = '0; dx_rs1_vld = 1'b0; dx_rs2_vld = 1'b0;
        dx_a = 32'hD1; dx_b = 32'hD2;
        clear_stages();
        xm_sw = 1'b0; xm_sw_rd = '0; xm_sw_data = '0;
        md_start = 1'b0; md_rd = '0; md_rdy = 1'b0; md_result = '0;
        step(); step();
        reset = 1'b0;
        #1;
        check("rst_busy",   32'(md_busy), 32'd0);
        check("rst_wb_en",  32'(md_wb_en), 32'd0);
        check("rst_wb_rd",  32'(md_wb_rd), 32'd0);
        check("rst_cnt",    32'(stall_cycles), 32'd0);
        check("rst_stall",  32'(stall), 32'd0);

        // Two stages writing r5: youngest wins
        stg_we = 2'b11; stg_rd = {5'd5, 5'd5}; stg_data = {32'hBBBB, 32'hAAAA};
        dx_rs1 = 5'd5; dx_rs1_vld = 1'b1;
        #1;
        check("fwd_youngest", alu_a, 32'hAAAA);
        stg_we = 2'b10; #1;
        check("fwd_older",    alu_a, 32'hBBBB);
        dx_rs1_vld = 1'b0; #1;
        check("fwd_not_vld",  alu_a, 32'hD1);

        // Exception redirects destination to r30
        clear_stages();
        stg_exc = 2'b10; stg_rd = {5'd3, 5'd0}; stg_data = {32'h3, 32'h0};
        dx_rs2 = 5'd30; dx_rs2_vld = 1'b1; #1;
        check("exc_r30",   alu_b, 32'h3);
        dx_rs2 = 5'd3; #1;
        check("exc_old_rd", alu_b, 32'hD2);
        dx_rs2 = 5'd0; stg_exc = 2'b00; stg_we = 2'b01; #1;
        check("r0_nofwd",  alu_b, 32'hD2);

        // Load-use
        clear_stages();
        stg_load = 2'b01; stg_we = 2'b01; stg_rd = {5'd0, 5'd7}; stg_data = {32'h0, 32'h77};
        dx_rs1 = 5'd7; dx_rs1_vld = 1'b1; dx_rs2_vld = 1'b0; #1;
        check("lu_stall", 32'(stall), 32'd1);
        check("lu_cnt0",  32'(stall_cycles), 32'd0);
        step();
        check("lu_cnt1",  32'(stall_cycles), 32'd1);
        dx_rs1_vld = 1'b0; #1;
        check("lu_novld", 32'(stall), 32'd0);
        step();
        check("lu_cnt_hold", 32'(stall_cycles), 32'd1);
        stg_rd = {5'd0, 5'd0}; dx_rs1 = 5'd0; dx_rs1_vld = 1'b1; #1;
        check("lu_r0", 32'(stall), 32'd0);

        // Multdiv to r9 with a dependent consumer
        clear_stages();
        dx_rs1_vld = 1'b0;
        md_start = 1'b1; md_rd = 5'd9;
        step();
        md_start = 1'b0;
        check("md_busy", 32'(md_busy), 32'd1);
        dx_rs1 = 5'd9; dx_rs1_vld = 1'b1; #1;
        check("md_stall1", 32'(stall), 32'd1);
        step();
        check("md_stall2", 32'(stall), 32'd1);
        check("md_wb_en_busy", 32'(md_wb_en), 32'd0);
        md_rdy = 1'b1;
        step();
        md_rdy = 1'b0; md_result = 32'h1234; #1;
        check("md_wb_en",  32'(md_wb_en), 32'd1);
        check("md_wb_rd",  32'(md_wb_rd), 32'd9);
        check("md_fwd",    alu_a, 32'h1234);
        check("md_wb_nostall", 32'(stall), 32'd0);
        check("md_cnt",    32'(stall_cycles), 32'd3);
        step();
        check("md_idle_en", 32'(md_wb_en), 32'd0);
        check("md_idle_rd", 32'(md_wb_rd), 32'd0);
        check("md_idle_a",  alu_a, 32'hD1);
        md_rdy = 1'b1;
        step();
        md_rdy = 1'b0;
        check("rdy_idle_busy", 32'(md_busy), 32'd0);
        check("rdy_idle_en",   32'(md_wb_en), 32'd0);

        // Start and ready in the same BUSY cycle
        dx_rs1_vld = 1'b0;
        md_start = 1'b1; md_rd = 5'd12;
        step();
        md_rd = 5'd13; md_rdy = 1'b1; #1;
        check("sr_stall", 32'(stall), 32'd1);
        step();
        md_rdy = 1'b0;
        check("sr_wb_en", 32'(md_wb_en), 32'd1);
        check("sr_wb_rd", 32'(md_wb_rd), 32'd12);
        check("sr_cnt",   32'(stall_cycles), 32'd4);
        step();
        check("sr_idle", 32'(md_busy), 32'd0);
        step();
        md_start = 1'b0;
        check("sr_recap", 32'(md_busy), 32'd1);
        md_rdy = 1'b1;
        step();
        md_rdy = 1'b0;
        check("sr_wb_rd2", 32'(md_wb_rd), 32'd13);
        step();

        // Start suppressed while load-use stalls
        stg_load = 2'b01; stg_we = 2'b01; stg_rd = {5'd0, 5'd7};
        dx_rs1 = 5'd7; dx_rs1_vld = 1'b1;
        md_start = 1'b1; md_rd = 5'd14;
        step();
        md_start = 1'b0;
        check("st_nocap", 32'(md_busy), 32'd0);
        check("st_cnt",   32'(stall_cycles), 32'd5);
        clear_stages(); dx_rs1_vld = 1'b0;

        // Reset while BUSY aborts the operation
        md_start = 1'b1; md_rd = 5'd9;
        step();
        md_start = 1'b0;
        check("ab_busy", 32'(md_busy), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("ab_idle",  32'(md_busy), 32'd0);
        check("ab_cnt",   32'(stall_cycles), 32'd0);
        md_rdy = 1'b1;
        step();
        md_rdy = 1'b0;
        check("ab_rdy_ign", 32'(md_wb_en), 32'd0);

        // md_rd = 0 runs but never interlocks
        md_start = 1'b1; md_rd = 5'd0;
        step();
        md_start = 1'b0;
        dx_rs1 = 5'd0; dx_rs1_vld = 1'b1; dx_rs2 = 5'd0; dx_rs2_vld = 1'b1; #1;
        check("z_busy",  32'(md_busy), 32'd1);
        check("z_stall", 32'(stall), 32'd0);
        md_rdy = 1'b1;
        step();
        md_rdy = 1'b0; md_result = 32'h55; #1;
        check("z_wb",  32'(md_wb_en), 32'd1);
        check("z_a",   alu_a, 32'hD1);
        step();
        dx_rs1_vld = 1'b0; dx_rs2_vld = 1'b0;

        // Store-data forwarding
        xm_sw = 1'b1; xm_sw_rd = 5'd4; xm_sw_data = 32'h11;
        stg_we = 2'b10; stg_rd = {5'd4, 5'd0}; stg_data = {32'h22, 32'h0}; #1;
        check("sw_fwd", dmem_data, 32'h22);
        stg_rd = {5'd0, 5'd0}; #1;
        check("sw_nomatch", dmem_data, 32'h11);
        stg_we = 2'b01; stg_rd = {5'd0, 5'd4}; stg_data = {32'h0, 32'h33}; #1;
        check("sw_xm_only", dmem_data, 32'h11);
        xm_sw = 1'b0; stg_we = 2'b10; stg_rd = {5'd4, 5'd0}; #1;
        check("sw_off", dmem_data, 32'h11);
        clear_stages(); xm_sw = 1'b0;

        // Counter saturation
        stg_load = 2'b01; stg_we = 2'b01; stg_rd = {5'd0, 5'd7};
        dx_rs1 = 5'd7; dx_rs1_vld = 1'b1;
        repeat (14) step();
        check("sat_14", 32'(stall_cycles), 32'd14);
        repeat (3) step();
        check("sat_15", 32'(stall_cycles), 32'd15);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
